// File: rtl/txpy_pkg.sv
// txpy_pkg: shared types, constants and FHS payload assembly for the TX payload serializer
package txpy_pkg;

    localparam logic [3:0] PK_FHS   = 4'h2;
    localparam int         FHS_BITS = 144;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    function automatic logic [FHS_BITS-1:0] fhs_assemble(
        input logic [27:0] clk28,
        input logic [2:0]  lt_addr,
        input logic [23:0] my_class,
        input logic [15:0] nap,
        input logic [7:0]  uap,
        input logic [1:0]  sr,
        input logic        eir,
        input logic [23:0] lap,
        input logic [33:0] syncword
    );
        return {3'b0, clk28[27:2], lt_addr, my_class, nap, uap, 2'b10, sr, 1'b0, eir, lap, syncword};
    endfunction

endpackage

// File: rtl/txpybuf_ram.sv
// txpybuf_ram: banked 1W1R byte RAM with {bank, addr} addressing and one-cycle read latency
module txpybuf_ram #(
    parameter int AW = 10,
    parameter int BW = 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [BW+AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [BW+AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [2**(BW+AW)];

    // write port and registered read port; contents are not reset
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/txpybuf_ser.sv
// txpybuf_ser: ping-pong payload buffer feeding an LSB-first bit serializer, with register-built FHS payloads
module txpybuf_ser
    import txpy_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int AW          = 10,
    parameter int NUM_BANKS   = 2
) (
    input  logic          clk_6M,
    input  logic          rst,
    input  logic          p_1us,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          wr_commit,
    output logic          buf_full,
    input  logic          mpr,
    input  logic          ir,
    input  logic [3:0]    pk_type,
    input  logic [12:0]   pylenbit,
    input  logic [27:0]   CLK,
    input  logic [2:0]    regi_FHS_LT_ADDR,
    input  logic [23:0]   regi_myClass,
    input  logic [15:0]   regi_my_BD_ADDR_NAP,
    input  logic [7:0]    regi_my_BD_ADDR_UAP,
    input  logic [1:0]    regi_SR,
    input  logic          regi_EIR,
    input  logic [23:0]   regi_my_BD_ADDR_LAP,
    input  logic [33:0]   regi_my_syncword,
    input  logic          tx_start,
    input  logic          tx_abort,
    output logic          pybitout,
    output logic          pybitvalid,
    output logic [12:0]   pybitcount,
    output logic          tx_done,
    output logic          underrun,
    output logic          wr_err
);

    localparam int          BW       = $clog2(NUM_BANKS);
    localparam logic [13:0] MAX_BITS = 14'(DEPTH_BYTES * 8);

    state_t                state_q, state_d;
    logic [BW-1:0]         fill_q, tx_q;
    logic [1:0]            cnt_q, cnt_d;
    logic [13:0]           len_q, len_d;
    logic [12:0]           bitcnt_q, bitcnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [7:0]            sr_q, sr_d;
    logic [FHS_BITS-1:0]   fhs_q, fhs_d;
    logic                  data_q, data_d;
    logic                  bit_q, bit_d;
    logic                  underrun_q, underrun_d;
    logic                  wr_err_q;
    logic [7:0]            rdata;
    logic [13:0]           plen, data_len;
    logic                  is_fhs, emit, last, cur_bit, commit_ok, release_bank;

    assign buf_full     = cnt_q == 2'(NUM_BANKS);
    assign is_fhs       = (pk_type == PK_FHS) | mpr | ir;
    assign emit         = (state_q == SHIFT) & p_1us & ~tx_abort;
    assign cur_bit      = data_q ? sr_q[0] : fhs_q[0];
    assign last         = ({1'b0, bitcnt_q} + 14'd1) == len_q;
    assign plen         = {1'b0, pylenbit};
    assign data_len     = (plen > MAX_BITS) ? MAX_BITS : plen;
    assign commit_ok    = wr_commit & ~buf_full;
    assign release_bank = (state_q == DONE) & data_q;
    assign cnt_d        = cnt_q + {1'b0, commit_ok} - {1'b0, release_bank};

    assign pybitvalid = emit;
    assign pybitout   = emit ? cur_bit : bit_q;
    assign pybitcount = bitcnt_q;
    assign tx_done    = state_q == DONE;
    assign underrun   = underrun_q;
    assign wr_err     = wr_err_q;

    // address 0 of the tx bank is read continuously while idle so LOAD finds the first byte ready
    txpybuf_ram #(.AW(AW), .BW(BW)) u_ram (
        .clk_i   (clk_6M),
        .we_i    (wr_en & ~buf_full),
        .waddr_i ({fill_q, wr_addr}),
        .wdata_i (wr_data),
        .raddr_i ({tx_q, (state_q == IDLE) ? '0 : addr_q}),
        .rdata_o (rdata)
    );

    // bank ownership: commits advance the fill side, data completions release the tx side
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            fill_q   <= '0;
            tx_q     <= '0;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            fill_q   <= fill_q + BW'(commit_ok);
            tx_q     <= tx_q + BW'(release_bank);
            cnt_q    <= cnt_d;
            wr_err_q <= (wr_en | wr_commit) & buf_full;
        end
    end

    // serializer state and datapath registers
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            bitcnt_q   <= '0;
            addr_q     <= '0;
            sr_q       <= '0;
            fhs_q      <= '0;
            data_q     <= 1'b0;
            bit_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            bitcnt_q   <= bitcnt_d;
            addr_q     <= addr_d;
            sr_q       <= sr_d;
            fhs_q      <= fhs_d;
            data_q     <= data_d;
            bit_q      <= bit_d;
            underrun_q <= underrun_d;
        end
    end

    // next-state: start decode, byte reload with prefetch at bit 4, abort and completion
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        bitcnt_d   = bitcnt_q;
        addr_d     = addr_q;
        sr_d       = sr_q;
        fhs_d      = fhs_q;
        data_d     = data_q;
        bit_d      = emit ? cur_bit : bit_q;
        underrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d   = '0;
                bitcnt_d = '0;
                if (tx_start) begin
                    if (is_fhs) begin
                        fhs_d   = fhs_assemble(CLK, regi_FHS_LT_ADDR, regi_myClass, regi_my_BD_ADDR_NAP,
                                               regi_my_BD_ADDR_UAP, regi_SR, regi_EIR,
                                               regi_my_BD_ADDR_LAP, regi_my_syncword);
                        len_d   = 14'(FHS_BITS);
                        data_d  = 1'b0;
                        state_d = LOAD;
                    end else if (cnt_q != 2'd0) begin
                        len_d   = data_len;
                        data_d  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                sr_d     = rdata;
                bitcnt_d = '0;
                state_d  = tx_abort ? IDLE : (len_q == 14'd0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (tx_abort) begin
                    state_d = IDLE;
                end else if (p_1us) begin
                    bitcnt_d = bitcnt_q + 13'd1;
                    fhs_d    = fhs_q >> 1;
                    sr_d     = (bitcnt_q[2:0] == 3'd7) ? rdata : (sr_q >> 1);
                    addr_d   = (bitcnt_q[2:0] == 3'd4) ? addr_q + AW'(1) : addr_q;
                    state_d  = last ? DONE : SHIFT;
                end
            end
            default: begin
                bitcnt_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_txpybuf_ser.sv
// tb_txpybuf_ser: scoreboard bench for the payload buffer/serializer
module tb_txpybuf_ser;

    logic        clk_6M, rst, p_1us, wr_en, wr_commit, buf_full, mpr, ir;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [3:0]  pk_type;
    logic [12:0] pylenbit;
    logic [27:0] CLK;
    logic [2:0]  regi_FHS_LT_ADDR;
    logic [23:0] regi_myClass;
    logic [15:0] regi_my_BD_ADDR_NAP;
    logic [7:0]  regi_my_BD_ADDR_UAP;
    logic [1:0]  regi_SR;
    logic        regi_EIR;
    logic [23:0] regi_my_BD_ADDR_LAP;
    logic [33:0] regi_my_syncword;
    logic        tx_start, tx_abort, pybitout, pybitvalid, tx_done, underrun, wr_err;
    logic [12:0] pybitcount;

    int          vectors = 0;
    int          miscompares = 0;
    int          nbit = 0;
    int          done_cnt = 0;
    int          div = 0;
    logic        exp_q[$];
    logic [7:0]  img [2][16];

    txpybuf_ser dut (
        .clk_6M(clk_6M), .rst(rst), .p_1us(p_1us),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit), .buf_full(buf_full),
        .mpr(mpr), .ir(ir), .pk_type(pk_type), .pylenbit(pylenbit), .CLK(CLK),
        .regi_FHS_LT_ADDR(regi_FHS_LT_ADDR), .regi_myClass(regi_myClass),
        .regi_my_BD_ADDR_NAP(regi_my_BD_ADDR_NAP), .regi_my_BD_ADDR_UAP(regi_my_BD_ADDR_UAP),
        .regi_SR(regi_SR), .regi_EIR(regi_EIR), .regi_my_BD_ADDR_LAP(regi_my_BD_ADDR_LAP),
        .regi_my_syncword(regi_my_syncword),
        .tx_start(tx_start), .tx_abort(tx_abort),
        .pybitout(pybitout), .pybitvalid(pybitvalid), .pybitcount(pybitcount),
        .tx_done(tx_done), .underrun(underrun), .wr_err(wr_err)
    );

    initial begin
        clk_6M = 1'b0;
        forever #5 clk_6M = ~clk_6M;
    end

    initial begin
        p_1us = 1'b0;
        forever begin
            @(posedge clk_6M);
            #1;
            div   = (div == 5) ? 0 : div + 1;
            p_1us = (div == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk_6M) begin
        if (!rst) begin
            if (pybitvalid) begin
                if (exp_q.size() == 0) check("extra_bit", 32'(pybitvalid), 32'd0);
                else begin
                    check("bit", 32'(pybitout), 32'(exp_q.pop_front()));
                    check("bitcount", 32'(pybitcount), 32'(nbit));
                end
                nbit++;
            end
            if (tx_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic write_byte(input logic [9:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    task automatic start();
        nbit = 0;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    task automatic load_bank(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            img[b][i] = 8'($urandom);
            write_byte(10'(i), img[b][i]);
        end
    endtask

    task automatic expect_bank(input int b, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(img[b][i / 8][i % 8]);
    endtask

    task automatic wait_done(input bit commit_at);
        int n = 0;
        while (!tx_done && n < 3000) begin
            tick();
            n++;
        end
        check("done_seen", 32'(tx_done), 32'd1);
        if (commit_at) wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_bits(input int n);
        int k = 0;
        while (nbit < n && k < 3000) begin
            tick();
            k++;
        end
        check("bits_reached", 32'(nbit >= n), 32'd1);
    endtask

    task automatic expect_underrun();
        start();
        check("underrun", 32'(underrun), 32'd1);
        tick();
        check("underrun_pulse", 32'(underrun), 32'd0);
    endtask

    initial begin
        logic [143:0] fv;
        logic [27:0]  clk28;
        int           seq[13] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1};
        int           d0;
        rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; wr_commit = 0; mpr = 0; ir = 0;
        pk_type = 4'h4; pylenbit = 0; CLK = 0; regi_FHS_LT_ADDR = 0; regi_myClass = 0;
        regi_my_BD_ADDR_NAP = 0; regi_my_BD_ADDR_UAP = 0; regi_SR = 0; regi_EIR = 0;
        regi_my_BD_ADDR_LAP = 0; regi_my_syncword = 0; tx_start = 0; tx_abort = 0;
        repeat (3) tick();
        check("reset_outs", 32'({pybitout, pybitvalid, pybitcount, tx_done, underrun, wr_err, buf_full}), 32'd0);
        rst = 1'b0;
        tick();

        clk28 = 28'h0ABCDEF;
        fv = '0;
        fv[57:34]   = 24'h9E8B33;
        fv[63:62]   = 2'b10;
        fv[140:115] = clk28[27:2];
        for (int i = 0; i < 144; i++) exp_q.push_back(fv[i]);
        pk_type = 4'h2; CLK = clk28; regi_my_BD_ADDR_LAP = 24'h9E8B33;
        start();
        CLK = 28'h1234567; regi_my_BD_ADDR_LAP = 24'h0;
        wait_done(1'b0);
        check("fhs_bits", 32'(nbit), 32'd144);
        check("fhs_no_full", 32'(buf_full), 32'd0);
        pk_type = 4'h4;
        expect_underrun();

        img[0][0] = 8'hA5; img[0][1] = 8'h3C;
        write_byte(10'd0, 8'hA5);
        write_byte(10'd1, 8'h3C);
        commit();
        check("one_commit_not_full", 32'(buf_full), 32'd0);
        for (int i = 0; i < 13; i++) exp_q.push_back(1'(seq[i]));
        pylenbit = 13'd13;
        start();
        wait_done(1'b0);
        check("data13_bits", 32'(nbit), 32'd13);
        repeat (3) tick();
        check("no_bits_underrun", 32'(nbit), 32'd13);
        expect_underrun();

        load_bank(1, 10);
        commit();
        load_bank(0, 10);
        commit();
        check("buf_full", 32'(buf_full), 32'd1);
        write_byte(10'd0, 8'hFF);
        check("wr_err_write", 32'(wr_err), 32'd1);
        tick();
        check("wr_err_pulse", 32'(wr_err), 32'd0);
        commit();
        check("wr_err_commit", 32'(wr_err), 32'd1);
        check("still_full", 32'(buf_full), 32'd1);

        pylenbit = 13'd80;
        expect_bank(1, 80);
        start();
        wait_bits(20);
        tx_abort = 1'b1;
        tick();
        tx_abort = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        repeat (30) tick();
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_keeps_full", 32'(buf_full), 32'd1);
        expect_bank(1, 80);
        start();
        wait_done(1'b0);
        check("after_release", 32'(buf_full), 32'd0);

        load_bank(1, 2);
        pylenbit = 13'd16;
        expect_bank(0, 16);
        start();
        wait_done(1'b1);
        check("swap_not_full", 32'(buf_full), 32'd0);
        expect_bank(1, 16);
        start();
        wait_done(1'b0);
        expect_underrun();

        load_bank(0, 1);
        commit();
        pylenbit = 13'd0;
        d0 = nbit;
        start();
        check("len0_not_yet", 32'(tx_done), 32'd0);
        tick();
        check("len0_done", 32'(tx_done), 32'd1);
        tick();
        check("len0_done_pulse", 32'(tx_done), 32'd0);
        check("len0_no_bits", 32'(nbit), 32'(d0));
        expect_underrun();

        load_bank(1, 10);
        commit();
        load_bank(0, 1);
        commit();
        pylenbit = 13'd80;
        expect_bank(1, 80);
        start();
        wait_bits(5);
        for (int k = 0; k < 20 && !p_1us; k++) begin
            @(posedge clk_6M);
            #3;
        end
        check("pre_rst_valid", 32'(pybitvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_outs", 32'({pybitout, pybitvalid, pybitcount, tx_done, underrun, wr_err, buf_full}), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        expect_underrun();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
